// File: rtl/riscv_pkg.sv
// Shared issue-stage constants and types for the reservation-station scheduler.
// Index widths are derived here so every block sizes its ports the same way.
package riscv_pkg;

  localparam int ROB_SIZE_DEF    = 16;
  localparam int NUM_RS_ROWS_DEF = 16;
  localparam int NUM_ALU         = 2;
  localparam int NUM_MEM         = 1;
  localparam int BUSY_W          = 3;

  // A width of at least 1 keeps degenerate single-entry configurations legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(NUM_RS_ROWS_DEF)-1:0] row_idx_t;
  typedef logic [idx_width(ROB_SIZE_DEF)-1:0]    rob_idx_t;

endpackage

// File: rtl/age_picker.sv
// Selects the oldest (smallest age) row that is eligible and not excluded.
// On equal ages the lower row number wins.
import riscv_pkg::*;

module age_picker #(
  parameter int NUM_ROWS = NUM_RS_ROWS_DEF,
  parameter int AW       = 4,
  parameter int RW       = idx_width(NUM_ROWS)
) (
  input  logic [NUM_ROWS-1:0]    eligible,
  input  logic [NUM_ROWS*AW-1:0] ages,
  input  logic [NUM_ROWS-1:0]    exclude,
  output logic                   valid,
  output logic [RW-1:0]          row
);

  logic [AW-1:0] best_age;

  // Strict less-than while scanning upward keeps the lowest row on ties.
  always_comb begin
    valid    = 1'b0;
    row      = '0;
    best_age = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (eligible[r] && !exclude[r] &&
          (!valid || (ages[r*AW +: AW] < best_age))) begin
        valid    = 1'b1;
        row      = RW'(r);
        best_age = ages[r*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// Oldest-first issue scheduler: two ALU ports and one memory port with a
// latency-based occupancy counter. Grants are registered (one cycle latency).
import riscv_pkg::*;

module issue_scheduler #(
  parameter int NUM_RS_ROWS = NUM_RS_ROWS_DEF,
  parameter int ROB_SIZE    = ROB_SIZE_DEF,
  parameter int MEM_LATENCY = 2,
  parameter int IW          = idx_width(ROB_SIZE),
  parameter int RW          = idx_width(NUM_RS_ROWS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [NUM_RS_ROWS-1:0]    rs_ready_i,
  input  logic [NUM_RS_ROWS-1:0]    rs_is_mem_i,
  input  logic [NUM_RS_ROWS*IW-1:0] rs_rob_index_i,
  input  logic [IW-1:0]             rob_head_i,
  output logic                      alu0_valid_o,
  output logic                      alu1_valid_o,
  output logic                      mem_valid_o,
  output logic [RW-1:0]             alu0_row_o,
  output logic [RW-1:0]             alu1_row_o,
  output logic [RW-1:0]             mem_row_o,
  output logic [NUM_RS_ROWS-1:0]    issued_mask_o,
  output logic                      mem_busy_o
);

  localparam logic [NUM_RS_ROWS-1:0] ROW_ONE = NUM_RS_ROWS'(1);

  logic [NUM_RS_ROWS-1:0]    pending_mask;
  logic [BUSY_W-1:0]         busy_cnt;
  logic [NUM_RS_ROWS*IW-1:0] ages;
  logic [NUM_RS_ROWS-1:0]    eligible;
  logic [NUM_RS_ROWS-1:0]    alu_eligible;
  logic [NUM_RS_ROWS-1:0]    mem_eligible;
  logic [NUM_RS_ROWS-1:0]    alu0_exclude;
  logic [NUM_RS_ROWS-1:0]    next_mask;
  logic [NUM_ALU+NUM_MEM-1:0] pick_valid;
  logic                      p0_valid, p1_valid, pm_valid;
  logic [RW-1:0]             p0_row, p1_row, pm_row;
  logic                      mem_grant;

  // Age is distance from the ROB head, so wrap-around needs no special case.
  always_comb begin
    ages = '0;
    for (int r = 0; r < NUM_RS_ROWS; r++) begin
      ages[r*IW +: IW] = rs_rob_index_i[r*IW +: IW] - rob_head_i;
    end
  end

  // Rows shown as issued this cycle are still marked ready until the RS drops them.
  assign eligible     = rs_ready_i & ~pending_mask;
  assign alu_eligible = eligible & ~rs_is_mem_i;
  assign mem_eligible = eligible & rs_is_mem_i;
  assign alu0_exclude = p0_valid ? (ROW_ONE << p0_row) : '0;

  age_picker #(.NUM_ROWS(NUM_RS_ROWS), .AW(IW), .RW(RW)) u_pick_alu0 (
    .eligible (alu_eligible),
    .ages     (ages),
    .exclude  ('0),
    .valid    (p0_valid),
    .row      (p0_row)
  );

  age_picker #(.NUM_ROWS(NUM_RS_ROWS), .AW(IW), .RW(RW)) u_pick_alu1 (
    .eligible (alu_eligible),
    .ages     (ages),
    .exclude  (alu0_exclude),
    .valid    (p1_valid),
    .row      (p1_row)
  );

  age_picker #(.NUM_ROWS(NUM_RS_ROWS), .AW(IW), .RW(RW)) u_pick_mem (
    .eligible (mem_eligible),
    .ages     (ages),
    .exclude  ('0),
    .valid    (pm_valid),
    .row      (pm_row)
  );

  assign pick_valid = {pm_valid, p1_valid, p0_valid};
  assign mem_grant  = pick_valid[NUM_ALU] && !mem_busy_o;

  always_comb begin
    next_mask = '0;
    if (pick_valid[0]) next_mask = next_mask | (ROW_ONE << p0_row);
    if (pick_valid[1]) next_mask = next_mask | (ROW_ONE << p1_row);
    if (mem_grant)     next_mask = next_mask | (ROW_ONE << pm_row);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      alu0_valid_o <= 1'b0;
      alu1_valid_o <= 1'b0;
      mem_valid_o  <= 1'b0;
      alu0_row_o   <= '0;
      alu1_row_o   <= '0;
      mem_row_o    <= '0;
      pending_mask <= '0;
      busy_cnt     <= '0;
    end else begin
      alu0_valid_o <= pick_valid[0];
      alu1_valid_o <= pick_valid[1];
      mem_valid_o  <= mem_grant;
      alu0_row_o   <= pick_valid[0] ? p0_row : '0;
      alu1_row_o   <= pick_valid[1] ? p1_row : '0;
      mem_row_o    <= mem_grant ? pm_row : '0;
      pending_mask <= next_mask;
      if (mem_grant)
        busy_cnt <= BUSY_W'(MEM_LATENCY);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - 1'b1;
    end
  end

  assign issued_mask_o = pending_mask;
  assign mem_busy_o    = (busy_cnt != '0);

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed-vector bench for issue_scheduler with default parameters
// (16 rows, ROB of 16, memory latency 2).
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic [15:0] rs_ready_i = '0;
  logic [15:0] rs_is_mem_i = '0;
  logic [63:0] rs_rob_index_i = '0;
  logic [3:0]  rob_head_i = '0;
  logic        alu0_valid_o, alu1_valid_o, mem_valid_o, mem_busy_o;
  logic [3:0]  alu0_row_o, alu1_row_o, mem_row_o;
  logic [15:0] issued_mask_o;

  int checks = 0;
  int failures = 0;

  issue_scheduler dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .flush_i        (flush_i),
    .rs_ready_i     (rs_ready_i),
    .rs_is_mem_i    (rs_is_mem_i),
    .rs_rob_index_i (rs_rob_index_i),
    .rob_head_i     (rob_head_i),
    .alu0_valid_o   (alu0_valid_o),
    .alu1_valid_o   (alu1_valid_o),
    .mem_valid_o    (mem_valid_o),
    .alu0_row_o     (alu0_row_o),
    .alu1_row_o     (alu1_row_o),
    .mem_row_o      (mem_row_o),
    .issued_mask_o  (issued_mask_o),
    .mem_busy_o     (mem_busy_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idx(input int row, input logic [3:0] idx);
    rs_rob_index_i[row*4 +: 4] = idx;
  endtask

  task automatic idle();
    rs_ready_i  = '0;
    rs_is_mem_i = '0;
    flush_i     = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    rs_ready_i = 16'h0003;
    step();
    step();
    checks++; if (alu0_valid_o !== 1'b0) begin failures++; $display("FAIL reset_alu0_valid got %0b exp 0", alu0_valid_o); end
    checks++; if (issued_mask_o !== 16'h0) begin failures++; $display("FAIL reset_mask got %h exp 0000", issued_mask_o); end
    checks++; if (mem_busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b exp 0", mem_busy_o); end
    rst_i = 1'b0;
    rs_ready_i = '0;
    step();
  endtask

  task automatic test_age_wrap();
    idle();
    rob_head_i = 4'd14;
    set_idx(3, 4'd1); set_idx(5, 4'd15); set_idx(9, 4'd14);
    rs_ready_i = 16'h0228;
    step();
    checks++; if (alu0_row_o !== 4'd9 || alu0_valid_o !== 1'b1) begin failures++; $display("FAIL wrap_alu0 got v=%0b r=%0d exp v=1 r=9", alu0_valid_o, alu0_row_o); end
    checks++; if (alu1_row_o !== 4'd5 || alu1_valid_o !== 1'b1) begin failures++; $display("FAIL wrap_alu1 got v=%0b r=%0d exp v=1 r=5", alu1_valid_o, alu1_row_o); end
    checks++; if (issued_mask_o !== 16'h0220) begin failures++; $display("FAIL wrap_mask got %h exp 0220", issued_mask_o); end
    checks++; if (mem_valid_o !== 1'b0 || mem_row_o !== 4'd0) begin failures++; $display("FAIL wrap_mem got v=%0b r=%0d exp v=0 r=0", mem_valid_o, mem_row_o); end
    rob_head_i = 4'd0;
  endtask

  task automatic test_no_reissue();
    logic [2:0] exp_v;
    exp_v = 3'b101;
    idle();
    set_idx(0, 4'd7);
    rs_ready_i = 16'h0001;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (alu0_valid_o !== exp_v[2-c]) begin failures++; $display("FAIL noreissue_c%0d got %0b exp %0b", c+1, alu0_valid_o, exp_v[2-c]); end
      checks++; if (alu1_valid_o !== 1'b0 || alu1_row_o !== 4'd0) begin failures++; $display("FAIL noreissue_alu1_c%0d got v=%0b r=%0d exp 0", c+1, alu1_valid_o, alu1_row_o); end
    end
  endtask

  task automatic test_mem_occupancy();
    logic [3:0] exp_mv;
    exp_mv = 4'b1001;
    idle();
    set_idx(2, 4'd5); set_idx(4, 4'd3);
    rs_ready_i  = 16'h0014;
    rs_is_mem_i = 16'h0014;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++; if (mem_valid_o !== exp_mv[3-c]) begin failures++; $display("FAIL memocc_valid_c%0d got %0b exp %0b", c+1, mem_valid_o, exp_mv[3-c]); end
      checks++; if (mem_row_o !== (exp_mv[3-c] ? 4'd4 : 4'd0)) begin failures++; $display("FAIL memocc_row_c%0d got %0d exp %0d", c+1, mem_row_o, exp_mv[3-c] ? 4 : 0); end
      if (c < 2) begin
        checks++; if (mem_busy_o !== 1'b1) begin failures++; $display("FAIL memocc_busy_c%0d got %0b exp 1", c+1, mem_busy_o); end
      end
    end
    checks++; if (alu0_valid_o !== 1'b0) begin failures++; $display("FAIL memocc_alu0 got %0b exp 0", alu0_valid_o); end
  endtask

  task automatic test_reset_mid_busy();
    idle();
    set_idx(6, 4'd2);
    rs_ready_i  = 16'h0040;
    rs_is_mem_i = 16'h0040;
    step();
    checks++; if (mem_busy_o !== 1'b1 || mem_valid_o !== 1'b1) begin failures++; $display("FAIL rstbusy_pre got busy=%0b v=%0b exp 1 1", mem_busy_o, mem_valid_o); end
    rst_i = 1'b1;
    step();
    checks++; if (mem_busy_o !== 1'b0) begin failures++; $display("FAIL rstbusy_busy got %0b exp 0", mem_busy_o); end
    checks++; if (mem_valid_o !== 1'b0 || mem_row_o !== 4'd0 || issued_mask_o !== 16'h0) begin failures++; $display("FAIL rstbusy_out got v=%0b r=%0d m=%h exp 0", mem_valid_o, mem_row_o, issued_mask_o); end
    rst_i = 1'b0;
    rs_ready_i = '0;
    step();
  endtask

  task automatic test_flush();
    idle();
    rob_head_i = 4'd4;
    set_idx(1, 4'd6); set_idx(2, 4'd4); set_idx(7, 4'd5);
    rs_ready_i = 16'h0086;
    flush_i = 1'b1;
    step();
    checks++; if ({alu0_valid_o, alu1_valid_o, mem_valid_o} !== 3'b000) begin failures++; $display("FAIL flush_valids got %b exp 000", {alu0_valid_o, alu1_valid_o, mem_valid_o}); end
    checks++; if (issued_mask_o !== 16'h0 || alu0_row_o !== 4'd0) begin failures++; $display("FAIL flush_mask got m=%h r=%0d exp 0", issued_mask_o, alu0_row_o); end
    flush_i = 1'b0;
    step();
    checks++; if (alu0_valid_o !== 1'b1 || alu0_row_o !== 4'd2) begin failures++; $display("FAIL flush_resume_alu0 got v=%0b r=%0d exp 1 2", alu0_valid_o, alu0_row_o); end
    checks++; if (alu1_valid_o !== 1'b1 || alu1_row_o !== 4'd7) begin failures++; $display("FAIL flush_resume_alu1 got v=%0b r=%0d exp 1 7", alu1_valid_o, alu1_row_o); end
    checks++; if (issued_mask_o !== 16'h0084) begin failures++; $display("FAIL flush_resume_mask got %h exp 0084", issued_mask_o); end
    rob_head_i = 4'd0;
  endtask

  task automatic test_mixed();
    idle();
    set_idx(6, 4'd2); set_idx(11, 4'd3);
    rs_ready_i  = 16'h0840;
    rs_is_mem_i = 16'h0800;
    step();
    checks++; if (alu0_valid_o !== 1'b1 || alu0_row_o !== 4'd6) begin failures++; $display("FAIL mixed_alu0 got v=%0b r=%0d exp 1 6", alu0_valid_o, alu0_row_o); end
    checks++; if (alu1_valid_o !== 1'b0 || alu1_row_o !== 4'd0) begin failures++; $display("FAIL mixed_alu1 got v=%0b r=%0d exp 0 0", alu1_valid_o, alu1_row_o); end
    checks++; if (mem_valid_o !== 1'b1 || mem_row_o !== 4'd11) begin failures++; $display("FAIL mixed_mem got v=%0b r=%0d exp 1 11", mem_valid_o, mem_row_o); end
    checks++; if (issued_mask_o !== 16'h0840) begin failures++; $display("FAIL mixed_mask got %h exp 0840", issued_mask_o); end
  endtask

  task automatic test_tie();
    idle();
    set_idx(4, 4'd9); set_idx(8, 4'd9); set_idx(12, 4'd10);
    rs_ready_i = 16'h1110;
    step();
    checks++; if (alu0_row_o !== 4'd4 || alu1_row_o !== 4'd8) begin failures++; $display("FAIL tie_rows got %0d,%0d exp 4,8", alu0_row_o, alu1_row_o); end
    step();
    checks++; if (alu0_row_o !== 4'd12 || alu1_valid_o !== 1'b0) begin failures++; $display("FAIL tie_next got r=%0d v1=%0b exp 12 0", alu0_row_o, alu1_valid_o); end
  endtask

  task automatic test_rst_and_flush();
    idle();
    set_idx(0, 4'd1);
    rs_ready_i = 16'h0001;
    step();
    rst_i = 1'b1;
    flush_i = 1'b1;
    step();
    checks++; if (alu0_valid_o !== 1'b0 || issued_mask_o !== 16'h0) begin failures++; $display("FAIL rstflush got v=%0b m=%h exp 0 0000", alu0_valid_o, issued_mask_o); end
    rst_i = 1'b0;
    flush_i = 1'b0;
    step();
    checks++; if (alu0_valid_o !== 1'b1 || alu0_row_o !== 4'd0) begin failures++; $display("FAIL rstflush_resume got v=%0b r=%0d exp 1 0", alu0_valid_o, alu0_row_o); end
  endtask

  initial begin
    test_reset();
    test_age_wrap();
    test_no_reissue();
    test_mem_occupancy();
    test_reset_mid_busy();
    test_flush();
    test_mixed();
    test_tie();
    test_rst_and_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
